tpm_response_tx: RTL
====================

# tpm_response_tx

Response-side byte transmitter for the TPM management path. It captures the response code produced by the management module, builds the 10-byte TPM response header (tag, responseSize, responseCode, all big-endian), and streams it out over a valid/ready byte interface toward the host link. On success it then forwards the command-handler body bytes. On error it emits the header only.

## Interface
- `BODY_W`, 16: width of the body-length field; maximum body is 2^BODY_W-1 bytes.
- `STALL_LIMIT`, 1024: idle cycles tolerated on the body input before abort. Used only with `TPM_RSP_STALL_TIMEOUT_EN`.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rsp_start`  in  1  one-cycle request to send a response; sampled only in IDLE.
- `rsp_tag`  in  16  requested tag (0x8001 no-sessions, 0x8002 sessions).
- `rsp_code`  in  32  TPM response code from the management module.
- `body_len`  in  BODY_W  number of body bytes following the header.
- `body_data`  in  8  body byte from the command handler.
- `body_valid`  in  1  body byte present.
- `body_ready`  out  1  body byte consumed this cycle.
- `tx_data`  out  8  outbound byte.
- `tx_valid`  out  1  outbound byte present.
- `tx_ready`  in  1  link accepts byte.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `done`  out  1  one-cycle pulse when the response is complete.
- `abort`  out  1  one-cycle pulse on stall timeout; tied 0 when the feature is compiled out.

## Operation
- FSM states: IDLE, HDR, BODY, DONE.
- IDLE:
  - On `rsp_start`, latch `rsp_code` and `body_len`.
  - Latch the tag as `rsp_tag` if `rsp_code`==0, else force it to 0x8001.
  - Effective length L = `body_len` if `rsp_code`==0, else 0.
  - size = 10 + L, zero-extended to 32 bits with no overflow.
  - Go to HDR with byte index 0.
- HDR:
  - Emit bytes 0..9 in order: tag[15:8], tag[7:0], size[31:24]..size[7:0], code[31:24]..code[7:0].
  - The index advances only on a cycle where `tx_valid`&`tx_ready`.
  - After byte 9 is accepted: go to BODY if L>0, else DONE.
- BODY, combinational pass-through:
  - `tx_data`=`body_data`, `tx_valid`=`body_valid`, `body_ready`=`tx_ready`.
  - A 16-bit down-counter loaded with L decrements on each handshake.
  - After the last byte is accepted, go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE.
- `rsp_start` outside IDLE is ignored; no queuing.
- `body_ready` is 0 outside BODY. Body bytes presented early are not consumed.
- Reset in any state returns to IDLE next edge. The partial frame is dropped and no `done` is issued.

## Timing
- Reset values: `tx_data`=0x00, `tx_valid`=0, `body_ready`=0, `busy`=0, `done`=0, `abort`=0, state=IDLE.
- `rsp_start` accepted at edge N:
  - `busy`=1 and `tx_valid`=1 carrying byte 0 from edge N+1.
  - Minimum frame is 10 cycles of header plus L cycles of body, then 1 DONE cycle.
  - Next start is accepted at the earliest in the cycle after DONE.
- Backpressure: in HDR, `tx_data`/`tx_valid` are registered and held stable while `tx_ready`=0.
- Body path adds zero latency; `tx_valid` may drop between body bytes.
- `done` and the IDLE transition coincide. `busy` falls in the same cycle `done` rises.

## Configuration
- `TPM_RSP_STALL_TIMEOUT_EN` defined:
  - In BODY, a counter counts consecutive cycles with `body_valid`=0, reset on any valid byte.
  - On reaching `STALL_LIMIT`: pulse `abort`, drive `body_ready`=0, force `tx_valid`=1 and `tx_data`=0x00.
  - Zero bytes continue until the remaining count is exhausted, then DONE, so the frame length stays equal to the advertised size.
- Undefined: no counter. BODY waits indefinitely; `abort` is constant 0.

## Test plan
- Success response: rsp_code=0, rsp_tag=0x8002, body_len=4, body AA BB CC DD, tx_ready=1 -> tx bytes 80 02 00 00 00 0E 00 00 00 00 AA BB CC DD; `done` pulses one cycle after DD is accepted.
- Error response: rsp_code=0x00000101, rsp_tag=0x8002, body_len=4 -> 80 01 00 00 00 0A 00 00 01 01; `body_ready` never asserts; `done` follows.
- Backpressure: tx_ready toggles 1,0,0,1 through the header -> each byte held stable while stalled, no byte skipped or duplicated, total 10 handshakes.
- Start while busy: second rsp_start with rsp_code=0x00000922 mid-header -> ignored; first frame completes unchanged.
- Reset mid-frame: reset asserted after byte 3 -> next edge `tx_valid`=0, `busy`=0, no `done`; a new start then produces a full header from byte 0.
- Stall timeout (macro defined, STALL_LIMIT=8): body_len=3, one byte 5A then body_valid=0 -> `abort` pulses after 8 idle cycles; tx emits 5A 00 00, then `done`.

Source files
------------

// File: rtl/tpm_response_tx.sv
// TPM response transmitter: builds the 10-byte big-endian response header and streams it, then the body bytes.
// Optional body stall timeout is compiled in with `define TPM_RSP_STALL_TIMEOUT_EN.
module tpm_response_tx #(
  parameter int BODY_W      = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rsp_start,
  input  logic [15:0]       rsp_tag,
  input  logic [31:0]       rsp_code,
  input  logic [BODY_W-1:0] body_len,
  input  logic [7:0]        body_data,
  input  logic              body_valid,
  output logic              body_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              abort
);

  typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} state_e;

  state_e            state_q, state_d;
  logic [79:0]       hdr_q, hdr_d;
  logic [3:0]        idx_q, idx_d;
  logic [BODY_W-1:0] remain_q, remain_d;
  logic [BODY_W-1:0] eff_len;
  logic [15:0]       eff_tag;
  logic [31:0]       size;
  logic              xfer;

`ifdef TPM_RSP_STALL_TIMEOUT_EN
  logic              stalled_q, stalled_d;
  logic              abort_q, abort_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
`endif

  if (BODY_W < 1 || BODY_W > 31) begin : g_bad_body_w
    $error("tpm_response_tx: BODY_W must be in 1..31");
  end
  if (STALL_LIMIT < 1) begin : g_bad_stall_limit
    $error("tpm_response_tx: STALL_LIMIT must be at least 1");
  end

  // The header is held as a shift register so the outbound byte is always a flop output.
  always_comb begin
    eff_len    = (rsp_code == 32'd0) ? body_len : '0;
    eff_tag    = (rsp_code == 32'd0) ? rsp_tag : 16'h8001;
    size       = 32'd10 + 32'(eff_len);
    state_d    = state_q;
    hdr_d      = hdr_q;
    idx_d      = idx_q;
    remain_d   = remain_q;
    xfer       = 1'b0;
    tx_data    = hdr_q[79:72];
    tx_valid   = 1'b0;
    body_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
`ifdef TPM_RSP_STALL_TIMEOUT_EN
    stalled_d   = stalled_q;
    stall_cnt_d = stall_cnt_q;
    abort_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (rsp_start) begin
          hdr_d    = {eff_tag, size, rsp_code};
          idx_d    = '0;
          remain_d = eff_len;
`ifdef TPM_RSP_STALL_TIMEOUT_EN
          stalled_d   = 1'b0;
          stall_cnt_d = '0;
`endif
          state_d  = HDR;
        end
      end
      HDR: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        if (tx_ready) begin
          hdr_d = {hdr_q[71:0], 8'h00};
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd9) begin
            idx_d   = '0;
            state_d = (remain_q != '0) ? BODY : DONE;
          end
        end
      end
      BODY: begin
        busy       = 1'b1;
        tx_data    = body_data;
        tx_valid   = body_valid;
        body_ready = tx_ready;
        xfer       = body_valid & tx_ready;
`ifdef TPM_RSP_STALL_TIMEOUT_EN
        // Once stalled, pad with zeros so the frame still matches the advertised size.
        if (stalled_q) begin
          tx_data    = 8'h00;
          tx_valid   = 1'b1;
          body_ready = 1'b0;
          xfer       = tx_ready;
        end else if (body_valid) begin
          stall_cnt_d = '0;
        end else if (stall_cnt_q == 32'(STALL_LIMIT - 1)) begin
          stalled_d = 1'b1;
          abort_d   = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + 32'd1;
        end
`endif
        if (xfer) begin
          remain_d = remain_q - BODY_W'(1);
          if (remain_q == BODY_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      hdr_q    <= '0;
      idx_q    <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      idx_q    <= idx_d;
      remain_q <= remain_d;
    end
  end

`ifdef TPM_RSP_STALL_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stalled_q   <= 1'b0;
      abort_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      stalled_q   <= stalled_d;
      abort_q     <= abort_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

endmodule
